div_iter: RTL

Multi-cycle 32-bit signed/unsigned divider for the MIPS CPU execute stage, implementing DIV/DIVU and writing quotient/remainder toward LO/HI. It sits downstream of the leading-zero counter: the `clz` unit counts leading zeros of the absolute dividend, and the radix-2 restoring loop uses that count to skip them. The CPU stalls on `busy` and captures `q`/`r` on the one-cycle `done` pulse.

---
 rtl/div_pkg.sv | 16 +
 rtl/clz.sv | 19 +
 rtl/div_iter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, widths and
// the quotient value returned on a divide by zero.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/clz.sv
// Combinational leading-zero counter. An all-zero input returns W.
module clz #(
  parameter int W  = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    // NOTE: count_o gets a default before the loop so no latch is inferred.
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) count_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU (quotient -> LO,
// remainder -> HI). Operands are converted to magnitudes on acceptance, one
// quotient bit is produced per ITER cycle, and signs are restored in FIX.
// Optional feature macro: DIV_ITER_EARLY_TERM_EN -- when defined, a clz unit
// pre-shifts the dividend past its leading zeros so only significant bits are
// iterated; otherwise every divide iterates 32 times. Results are identical.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  div_state_e           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0]     rem_q, dvd_q, dvs_q, raw_q;
  logic                 q_neg_q, r_neg_q, dbz_pend_q;
  logic [DIV_W-1:0]     q_q, r_q;
  logic                 busy_q, done_q, dbz_q;

  // Acceptance-side operand conditioning.
  logic                 dvd_neg, dvs_neg, dvs_zero;
  logic [DIV_W-1:0]     dvd_abs, dvs_abs, dvd_norm;
  logic [DIV_CNT_W-1:0] lz, cnt_init;

  assign dvd_neg  = is_signed & dividend[DIV_W-1];
  assign dvs_neg  = is_signed & divisor[DIV_W-1];
  assign dvs_zero = (divisor == '0);
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  assign dvd_abs  = dvd_neg ? -dividend : dividend;
  assign dvs_abs  = dvs_neg ? -divisor  : divisor;

`ifdef DIV_ITER_EARLY_TERM_EN
  clz #(.W(DIV_W), .CW(DIV_CNT_W)) u_clz (
    .data_i  (dvd_abs),
    .count_o (lz)
  );
`else
  assign lz = '0;
`endif

  // A zero dividend gives lz = 32: the shift clears dvd and N becomes 0.
  assign dvd_norm = dvd_abs << lz;
  assign cnt_init = DIV_CNT_W'(DIV_W) - lz;

  // One restoring step: 33-bit trial subtraction of the shifted remainder.
  logic [DIV_W:0]   rem_sh, trial;
  logic             q_bit;
  logic [DIV_W-1:0] rem_d, dvd_d;

  assign rem_sh = {rem_q, dvd_q[DIV_W-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign q_bit  = ~trial[DIV_W];
  assign rem_d  = q_bit ? trial[DIV_W-1:0] : rem_sh[DIV_W-1:0];
  assign dvd_d  = {dvd_q[DIV_W-2:0], q_bit};

  // Sign restoration; divide by zero returns all-ones and the raw dividend.
  logic [DIV_W-1:0] q_d, r_d;

  assign q_d = dbz_pend_q ? DIV_ZERO_Q : (q_neg_q ? -dvd_q : dvd_q);
  assign r_d = dbz_pend_q ? raw_q      : (r_neg_q ? -rem_q : rem_q);

  // Control FSM and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      raw_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dbz_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_q      <= '0;
            dvd_q      <= dvd_norm;
            dvs_q      <= dvs_abs;
            raw_q      <= dividend;
            q_neg_q    <= dvd_neg ^ dvs_neg;
            r_neg_q    <= dvd_neg;
            dbz_pend_q <= dvs_zero;
            cnt_q      <= dvs_zero ? '0 : cnt_init;
            busy_q     <= 1'b1;
            state_q    <= (dvs_zero || cnt_init == '0) ? ST_FIX : ST_ITER;
          end
        end
        ST_ITER: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == DIV_CNT_W'(1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          q_q     <= q_d;
          r_q     <= r_d;
          dbz_q   <= dbz_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule
